// File: rtl/instruction_execute.sv
// instruction_execute: execute stage of the 3-bit chronospatial CPU.
//
// Retires the instruction presented by fetch (opcode/operand at address
// instr_ptr_if_reg), owns registers A/B/C and drives the fetch address.
// Fetch runs one instruction ahead of execute, so instr_ptr normally leads
// instr_ptr_if_reg by two. A taken jump loads instr_ptr with the target and
// squashes the single wrong-path instruction that is already in fetch.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   pulse: load init_a/b/c and begin a run (IDLE/DONE only)
//   init_a/b/c              initial register values
//   opcode, operand         instruction from fetch
//   instr_ptr_if_reg        address of the instruction held by fetch
//   instr_ptr               registered fetch address
//   halt                    freezes fetch (not running, or output stalled)
//   out_data/out_valid      output value and its valid flag
//   out_ready               consumer accepts out_data
//   busy, done, err         run status; err is sticky until the next start
//   reg_a/reg_b/reg_c       architectural registers
//   steps                   instructions retired in this run
module instruction_execute #(
  parameter int REG_W     = 32,
  parameter int MAX_STEPS = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REG_W-1:0] init_a,
  input  logic [REG_W-1:0] init_b,
  input  logic [REG_W-1:0] init_c,
  input  logic [2:0]       opcode,
  input  logic [2:0]       operand,
  input  logic [3:0]       instr_ptr_if_reg,
  output logic [3:0]       instr_ptr,
  output logic             halt,
  output logic [2:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REG_W-1:0] reg_a,
  output logic [REG_W-1:0] reg_b,
  output logic [REG_W-1:0] reg_c,
  output logic [15:0]      steps
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [REG_W-1:0] SHIFT_LIMIT = REG_W'(REG_W);
  localparam logic [15:0]      STEP_LIMIT  = 16'(MAX_STEPS);

  state_t           state;
  logic             squash;
  logic             stall;
  logic [REG_W-1:0] combo;
  logic             combo_bad;
  logic             uses_combo;
  logic             jump_taken;
  logic [15:0]      steps_next;

  // Logical right shift that saturates to zero for oversized amounts.
  function automatic logic [REG_W-1:0] shr(input logic [REG_W-1:0] x,
                                           input logic [REG_W-1:0] amt);
    if (amt >= SHIFT_LIMIT) begin
      return {REG_W{1'b0}};
    end else begin
      return x >> amt;
    end
  endfunction

  assign stall      = out_valid & ~out_ready;
  assign halt       = (state != RUN) | stall;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign jump_taken = (opcode == 3'd3) && (reg_a != {REG_W{1'b0}});
  assign steps_next = steps + 16'd1;

  // Combo operand decode; operand 7 is reserved and flags an error.
  always_comb begin
    combo     = {REG_W{1'b0}};
    combo_bad = 1'b0;
    case (operand)
      3'd4:    combo = reg_a;
      3'd5:    combo = reg_b;
      3'd6:    combo = reg_c;
      3'd7:    combo_bad = 1'b1;
      default: combo = REG_W'(operand);
    endcase
  end

  // Only adv, bst, out, bdv and cdv interpret the operand as a combo operand.
  always_comb begin
    case (opcode)
      3'd0, 3'd2, 3'd5, 3'd6, 3'd7: uses_combo = 1'b1;
      default:                      uses_combo = 1'b0;
    endcase
  end

  // Run-control FSM, register file, instruction pointer and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      squash    <= 1'b0;
      instr_ptr <= 4'd0;
      out_data  <= 3'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      reg_a     <= {REG_W{1'b0}};
      reg_b     <= {REG_W{1'b0}};
      reg_c     <= {REG_W{1'b0}};
      steps     <= 16'd0;
    end else begin
      // An accepted output drops valid; a retiring out below overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (start && !out_valid) begin
            reg_a     <= init_a;
            reg_b     <= init_b;
            reg_c     <= init_c;
            instr_ptr <= 4'd0;
            steps     <= 16'd0;
            err       <= 1'b0;
            squash    <= 1'b1;   // fetch still holds a stale instruction
            state     <= RUN;
          end
        end
        RUN: begin
          if (stall) begin
            // hold everything until the consumer takes the pending output
          end else if (squash) begin
            instr_ptr <= instr_ptr + 4'd2;
            squash    <= 1'b0;
          end else if (uses_combo && combo_bad) begin
            state <= DONE;
            err   <= 1'b1;
          end else if (jump_taken && operand[0]) begin
            state <= DONE;
            err   <= 1'b1;
          end else begin
            steps     <= steps_next;
            instr_ptr <= instr_ptr + 4'd2;
            case (opcode)
              3'd0: reg_a <= shr(reg_a, combo);
              3'd1: reg_b <= reg_b ^ REG_W'(operand);
              3'd2: reg_b <= REG_W'(combo[2:0]);
              3'd3: begin
                if (jump_taken) begin
                  instr_ptr <= {1'b0, operand};
                  squash    <= 1'b1;
                end
              end
              3'd4: reg_b <= reg_b ^ reg_c;
              3'd5: begin
                out_data  <= combo[2:0];
                out_valid <= 1'b1;
              end
              3'd6: reg_b <= shr(reg_a, combo);
              3'd7: reg_c <= shr(reg_a, combo);
              default: reg_a <= reg_a;
            endcase
            if (steps_next == STEP_LIMIT) begin
              state <= DONE;
              err   <= 1'b1;
            end else if ((instr_ptr_if_reg == 4'd14) && !jump_taken) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_execute.sv
module tb_instruction_execute;
  localparam int REG_W     = 32;
  localparam int MAX_STEPS = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [REG_W-1:0] init_a, init_b, init_c;
  logic [2:0]       opcode, operand;
  logic [3:0]       instr_ptr_if_reg;
  logic [3:0]       instr_ptr;
  logic             halt;
  logic [2:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy, done, err;
  logic [REG_W-1:0] reg_a, reg_b, reg_c;
  logic [15:0]      steps;

  int checks = 0;
  int fails  = 0;
  logic [2:0] exp_q[$];
  logic [2:0] prog[16];

  always #5 clk = ~clk;

  instruction_execute #(.REG_W(REG_W), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .init_a(init_a), .init_b(init_b), .init_c(init_c),
    .opcode(opcode), .operand(operand), .instr_ptr_if_reg(instr_ptr_if_reg),
    .instr_ptr(instr_ptr), .halt(halt),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .steps(steps)
  );

  // Fetch model: registers the instruction at instr_ptr unless halted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode           <= 3'd0;
      operand          <= 3'd0;
      instr_ptr_if_reg <= 4'd0;
    end else if (!halt) begin
      opcode           <= prog[instr_ptr];
      operand          <= prog[instr_ptr + 4'd1];
      instr_ptr_if_reg <= instr_ptr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every accepted transfer is compared against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_data), 32'd99);
      end else begin
        chk("out_stream", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Six leading slots, slot 0 in the top bits; the rest are zero.
  task automatic set_prog(input logic [17:0] w);
    for (int i = 0; i < 16; i++) prog[i] = 3'd0;
    for (int i = 0; i < 6; i++) prog[i] = w[17-3*i -: 3];
  endtask

  task automatic push_outs(input int n, input logic [29:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v[29-3*i -: 3]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                           input logic [REG_W-1:0] c);
    init_a = a; init_b = b; init_c = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(done), 32'd1);
    repeat (3) tick();  // let a pending final output drain
  endtask

  logic [3:0]  ip_hold;
  logic [15:0] steps_hold;
  int          n;

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    init_a = '0; init_b = '0; init_c = '0;
    set_prog(18'd0);
    repeat (3) tick();
    chk("rst_ip", 32'(instr_ptr), 32'd0);
    chk("rst_outs", {28'd0, out_valid, busy, done, err}, 32'd0);
    chk("rst_halt", 32'(halt), 32'd1);
    chk("rst_a", reg_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // Example program: A>>=1, out A, loop while A!=0.
    set_prog({3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0});
    push_outs(10, {3'd4, 3'd6, 3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0});
    start_run(32'd729, 32'd0, 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    wait_done("ex_done", 200);
    chk("ex_err", 32'(err), 32'd0);
    chk("ex_a", reg_a, 32'd0);
    chk("ex_steps", 32'(steps), 32'd35);
    chk("ex_drained", 32'(exp_q.size()), 32'd0);

    // Same program with the first output held off for five cycles.
    out_ready = 1'b0;
    push_outs(10, {3'd4, 3'd6, 3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0});
    start_run(32'd729, 32'd0, 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    ip_hold = instr_ptr;
    steps_hold = steps;
    for (int i = 0; i < 5; i++) begin
      chk("bp_halt", 32'(halt), 32'd1);
      chk("bp_data", 32'(out_data), 32'd4);
      chk("bp_ip", 32'(instr_ptr), 32'(ip_hold));
      tick();
    end
    chk("bp_steps", 32'(steps), 32'(steps_hold));
    out_ready = 1'b1;
    wait_done("bp_done", 200);
    chk("bp_err", 32'(err), 32'd0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // bst A; bxl 5; out B.
    set_prog({3'd2, 3'd4, 3'd1, 3'd5, 3'd5, 3'd5});
    push_outs(1, {3'd0, 27'd0});
    start_run(32'd13, 32'd0, 32'd0);
    wait_done("p2_done", 100);
    chk("p2_b", reg_b, 32'd0);
    chk("p2_a", reg_a, 32'd13);
    chk("p2_steps", 32'(steps), 32'd8);
    chk("p2_err", 32'(err), 32'd0);

    // Reserved combo operand.
    set_prog({3'd0, 3'd7, 12'd0});
    start_run(32'd100, 32'd0, 32'd0);
    wait_done("c7_done", 50);
    chk("c7_err", 32'(err), 32'd1);
    chk("c7_a", reg_a, 32'd100);
    chk("c7_steps", 32'(steps), 32'd0);

    // New start clears err: bst A (6), bxl 5 -> 3, out 3.
    set_prog({3'd2, 3'd4, 3'd1, 3'd5, 3'd5, 3'd5});
    push_outs(1, {3'd3, 27'd0});
    start_run(32'd6, 32'd0, 32'd0);
    chk("restart_err", 32'(err), 32'd0);
    wait_done("p2b_done", 100);
    chk("p2b_b", reg_b, 32'd3);
    chk("p2b_err", 32'(err), 32'd0);

    // Odd jump target.
    set_prog({3'd3, 3'd1, 12'd0});
    start_run(32'd1, 32'd0, 32'd0);
    wait_done("odd_done", 50);
    chk("odd_err", 32'(err), 32'd1);
    chk("odd_steps", 32'(steps), 32'd0);

    // Infinite jnz loop hits the step limit.
    set_prog({3'd3, 3'd0, 12'd0});
    start_run(32'd1, 32'd0, 32'd0);
    wait_done("lim_done", 500);
    chk("lim_err", 32'(err), 32'd1);
    chk("lim_steps", 32'(steps), 32'(MAX_STEPS));

    // start ignored while busy, then asynchronous reset mid-run.
    start_run(32'd1, 32'd0, 32'd0);
    repeat (6) tick();
    steps_hold = steps;
    start_run(32'd5, 32'd0, 32'd0);
    chk("busy_start_a", reg_a, 32'd1);
    chk("busy_start_steps", 32'(steps == steps_hold || steps == steps_hold + 16'd1), 32'd1);
    chk("busy_still", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {28'd0, out_valid, busy, done, err}, 32'd0);
    chk("arst_a", reg_a, 32'd0);
    chk("arst_steps", 32'(steps), 32'd0);
    chk("arst_ip", 32'(instr_ptr), 32'd0);
    chk("arst_halt", 32'(halt), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
